// File: rtl/conversor_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter.
//   estado_t        : controller states (OCIOSO, CONVERTE, CARREGA)
//   LARGURA_PADRAO  : default binary input width / iteration count
//   MAXIMO_PADRAO   : largest value representable in four BCD digits
//   APAGADO         : code loaded on overflow; the display decoder blanks it
package conversor_bcd_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    CARREGA  = 2'd2
  } estado_t;

  localparam int          LARGURA_PADRAO = 14;
  localparam int          MAXIMO_PADRAO  = 9999;
  localparam logic [15:0] APAGADO        = 16'hFFFF;

endpackage

// File: rtl/conversor_bcd_ajuste_digito.sv
// Double-dabble correction for one BCD nibble.
//   digito   : current scratch nibble
//   ajustado : digito + 3 when digito >= 5, otherwise digito unchanged
module ajuste_digito (
  input  logic [3:0] digito,
  output logic [3:0] ajustado
);

  assign ajustado = (digito >= 4'd5) ? (digito + 4'd3) : digito;

endmodule

// File: rtl/conversor_bcd.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle).
//   clock       : single clock, rising edge
//   reset       : asynchronous, active-high
//   inicio      : start request, sampled in OCIOSO only
//   valor       : unsigned binary input, sampled with inicio
//   registrador : packed 4-digit BCD result (digit 0 in [3:0]), held between loads
//   ocupado     : high while the conversion steps run
//   pronto      : one-cycle pulse on the edge that loads registrador
//   erro        : overflow flag of the last load, APAGADO is loaded with it
module conversor_bcd
  import conversor_bcd_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO,
  parameter int MAXIMO  = MAXIMO_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inicio,
  input  logic [LARGURA-1:0] valor,
  output logic [15:0]        registrador,
  output logic               ocupado,
  output logic               pronto,
  output logic               erro
);

  localparam int          CW     = $clog2(LARGURA + 1);
  localparam logic [31:0] LIMITE = MAXIMO;

  estado_t            estado;
  logic [CW-1:0]      contador;
  logic [15:0]        rascunho;
  logic [15:0]        rascunhoAjustado;
  logic [LARGURA-1:0] deslocador;
  logic               excedeu;

  // Overflowed conversions run the full schedule but load the blank code.
  function automatic logic [15:0] saturaBcd(input logic [15:0] bcd, input logic estouro);
    return estouro ? APAGADO : bcd;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gDigito
    ajuste_digito uAjuste (
      .digito   (rascunho[4*g +: 4]),
      .ajustado (rascunhoAjustado[4*g +: 4])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado      <= OCIOSO;
      contador    <= '0;
      rascunho    <= '0;
      deslocador  <= '0;
      excedeu     <= 1'b0;
      registrador <= 16'h0000;
      ocupado     <= 1'b0;
      pronto      <= 1'b0;
      erro        <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          pronto  <= 1'b0;
          ocupado <= 1'b0;
          if (inicio) begin
            deslocador <= valor;
            rascunho   <= '0;
            contador   <= '0;
            excedeu    <= (32'(valor) > LIMITE);
            estado     <= CONVERTE;
          end
        end
        CONVERTE: begin
          ocupado    <= 1'b1;
          // {rascunho, deslocador} shifts left as one word after correction.
          rascunho   <= {rascunhoAjustado[14:0], deslocador[LARGURA-1]};
          deslocador <= deslocador << 1;
          contador   <= contador + 1'b1;
          if (contador == CW'(LARGURA - 1)) begin
            estado <= CARREGA;
          end
        end
        CARREGA: begin
          registrador <= saturaBcd(rascunho, excedeu);
          erro        <= excedeu;
          pronto      <= 1'b1;
          ocupado     <= 1'b0;
          estado      <= OCIOSO;
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conversor_bcd.sv
// Self-checking bench for conversor_bcd: directed corner cases plus random
// values compared against a decimal-arithmetic reference model.
module tb_conversor_bcd;

  localparam int LARGURA = 14;
  localparam int LATENCIA = LARGURA + 1;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               inicio = 1'b0;
  logic [LARGURA-1:0] valor = '0;
  logic [15:0]        registrador;
  logic               ocupado;
  logic               pronto;
  logic               erro;

  int checks = 0;
  int errors = 0;

  conversor_bcd #(.LARGURA(LARGURA), .MAXIMO(9999)) dut (
    .clock       (clock),
    .reset       (reset),
    .inicio      (inicio),
    .valor       (valor),
    .registrador (registrador),
    .ocupado     (ocupado),
    .pronto      (pronto),
    .erro        (erro)
  );

  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, esp);
    end
  endtask

  // Reference: decimal digits by plain arithmetic, blank code above 9999.
  function automatic logic [15:0] modeloBcd(input int v);
    if (v > 9999) return 16'hFFFF;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic modeloErro(input int v);
    return v > 9999;
  endfunction

  // Presents a start request; returns #1 after the sampling edge.
  task automatic iniciar(input int v);
    @(negedge clock);
    inicio = 1'b1;
    valor  = LARGURA'(v);
    @(posedge clock);
    #1;
    inicio = 1'b0;
  endtask

  // Waits (bounded) for pronto; reports edges since the sampling edge,
  // cycles with ocupado high, and whether registrador/erro moved early.
  task automatic esperaPronto(output int arestas, output int ciclosOcupado, output int mudancas);
    logic [15:0] regInicial;
    logic        erroInicial;
    regInicial    = registrador;
    erroInicial   = erro;
    arestas       = -1;
    ciclosOcupado = 0;
    mudancas      = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (pronto) begin
        arestas = n;
        break;
      end
      if (ocupado) ciclosOcupado++;
      if (registrador !== regInicial || erro !== erroInicial) mudancas++;
    end
  endtask

  task automatic converteConfere(input int v, input string tag);
    int arestas, ciclosOcupado, mudancas;
    iniciar(v);
    esperaPronto(arestas, ciclosOcupado, mudancas);
    verifica({tag, "_latencia"}, arestas, LATENCIA);
    verifica({tag, "_registrador"}, registrador, modeloBcd(v));
    verifica({tag, "_erro"}, erro, modeloErro(v));
    verifica({tag, "_estavel"}, mudancas, 0);
  endtask

  initial begin
    int arestas, ciclosOcupado, mudancas, pulsos;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    verifica("reset_saidas", {registrador, ocupado, pronto, erro}, 0);
    @(negedge clock);
    reset = 1'b0;

    // Zero, with latency and pronto width
    converteConfere(0, "zero");
    @(posedge clock);
    #1;
    verifica("pronto_um_ciclo", pronto, 0);

    converteConfere(1234, "v1234");

    iniciar(9999);
    esperaPronto(arestas, ciclosOcupado, mudancas);
    verifica("v9999_latencia", arestas, LATENCIA);
    verifica("v9999_registrador", registrador, 16'h9999);
    verifica("v9999_erro", erro, 0);
    verifica("v9999_ocupado_ciclos", ciclosOcupado, 14);
    verifica("v9999_ocupado_no_pronto", ocupado, 0);

    converteConfere(10000, "v10000");
    converteConfere(16383, "v16383");
    converteConfere(42, "v42");

    // Start request while busy is ignored
    iniciar(500);
    pulsos  = 0;
    arestas = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (n == 3) begin
        verifica("ocupado_meio", ocupado, 1);
        inicio = 1'b1;
        valor  = LARGURA'(77);
      end
      if (n == 6) inicio = 1'b0;
      if (pronto) begin
        pulsos++;
        if (arestas < 0) arestas = n;
      end
    end
    verifica("ignora_latencia", arestas, LATENCIA);
    verifica("ignora_registrador", registrador, 16'h0500);
    verifica("ignora_pulsos", pulsos, 1);

    // Asynchronous reset mid-conversion
    iniciar(8888);
    repeat (7) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    verifica("reset_meio_saidas", {registrador, ocupado, pronto, erro}, 0);
    pulsos = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clock);
      #1;
      if (pronto) pulsos++;
    end
    verifica("reset_meio_sem_pronto", pulsos, 0);
    @(negedge clock);
    reset = 1'b0;
    converteConfere(31, "pos_reset31");

    // Back-to-back: start accepted in the pronto cycle
    iniciar(12);
    esperaPronto(arestas, ciclosOcupado, mudancas);
    verifica("seq12_latencia", arestas, LATENCIA);
    verifica("seq12_registrador", registrador, 16'h0012);
    inicio = 1'b1;
    valor  = LARGURA'(65);
    @(posedge clock);
    #1;
    inicio = 1'b0;
    verifica("seq_pronto_cai", pronto, 0);
    esperaPronto(arestas, ciclosOcupado, mudancas);
    verifica("seq65_latencia", arestas, LATENCIA);
    verifica("seq65_registrador", registrador, 16'h0065);
    verifica("seq65_erro", erro, 0);

    // Random values across the whole input range
    for (int i = 0; i < 24; i++) begin
      int v;
      v = (i % 4 == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
      converteConfere(v, $sformatf("rand%0d_v%0d", i, v));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
